// File: rtl/rgb_serial_tx.sv
// rgb_serial_tx: parallel RGB pixel to bit-serial slot transmitter.
// Each pixel occupies one fixed slot of SLOT_BITS cycles on pred/pgreen/pblu,
// LSB first; idle slots carry all-zero bubbles so the line never stops.
// Optional return path (compiled in when RGB_TX_RESULT_EN is defined)
// reassembles the converter's MSB-first grey stream and black flag.
module rgb_serial_tx #(
  parameter int SLOT_BITS = 8
) (
  input  logic                 r_to_v_clk,
  input  logic                 r_to_v_rst_n,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [SLOT_BITS-1:0] pix_red,
  input  logic [SLOT_BITS-1:0] pix_green,
  input  logic [SLOT_BITS-1:0] pix_blue,
  output logic                 pred,
  output logic                 pgreen,
  output logic                 pblu,
  output logic                 slot_start,
  input  logic                 grey_in,
  input  logic                 black_in,
  output logic                 res_valid,
  output logic [SLOT_BITS-1:0] grey_out,
  output logic                 black_out
);

  localparam int IDX_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOT_BITS - 1);

  logic [IDX_W-1:0]     bit_idx;
  logic                 slot_end;
  logic                 hs;
  logic                 hold_full;
  logic                 sh_real;
  logic [SLOT_BITS-1:0] hold_r, hold_g, hold_b;
  logic [SLOT_BITS-1:0] sh_r, sh_g, sh_b;

  assign slot_end  = (bit_idx == LAST_IDX);
  // Handshake: a pixel transfers on the rising edge where pix_valid and
  // pix_ready are both high; pix_ready depends only on registered state, and
  // the source must keep the pixel stable while pix_valid waits for pix_ready.
  assign hs        = pix_valid & pix_ready;
  assign hold_full = ~pix_ready;

  // Free-running slot cycle counter; the converter has no framing of its own.
  always_ff @(posedge r_to_v_clk or negedge r_to_v_rst_n) begin
    if (!r_to_v_rst_n) begin
      bit_idx    <= '0;
      slot_start <= 1'b1;
    end else begin
      bit_idx    <= slot_end ? '0 : bit_idx + 1'b1;
      slot_start <= slot_end;
    end
  end

  // One-entry hold register; pix_ready is its registered empty flag.
  always_ff @(posedge r_to_v_clk or negedge r_to_v_rst_n) begin
    if (!r_to_v_rst_n) begin
      pix_ready <= 1'b1;
      hold_r    <= '0;
      hold_g    <= '0;
      hold_b    <= '0;
    end else if (slot_end && hold_full) begin
      pix_ready <= 1'b1;
    end else if (hs && !slot_end) begin
      // A handshake on the boundary edge bypasses the hold register.
      pix_ready <= 1'b0;
      hold_r    <= pix_red;
      hold_g    <= pix_green;
      hold_b    <= pix_blue;
    end
  end

  // Channel shifters: load a pixel or a bubble at the boundary, else shift LSB out.
  always_ff @(posedge r_to_v_clk or negedge r_to_v_rst_n) begin
    if (!r_to_v_rst_n) begin
      sh_r    <= '0;
      sh_g    <= '0;
      sh_b    <= '0;
      sh_real <= 1'b0;
    end else if (slot_end) begin
      if (hold_full) begin
        sh_r    <= hold_r;
        sh_g    <= hold_g;
        sh_b    <= hold_b;
        sh_real <= 1'b1;
      end else if (hs) begin
        sh_r    <= pix_red;
        sh_g    <= pix_green;
        sh_b    <= pix_blue;
        sh_real <= 1'b1;
      end else begin
        sh_r    <= '0;
        sh_g    <= '0;
        sh_b    <= '0;
        sh_real <= 1'b0;
      end
    end else begin
      sh_r <= sh_r >> 1;
      sh_g <= sh_g >> 1;
      sh_b <= sh_b >> 1;
    end
  end

  assign pred   = sh_r[0];
  assign pgreen = sh_g[0];
  assign pblu   = sh_b[0];

`ifdef RGB_TX_RESULT_EN
  logic [SLOT_BITS-1:0] grey_sh;
  logic                 tag_q;
  logic                 black_q;

  // Grey arrives MSB first, so shifting in at the bottom leaves bit 7 on top.
  always_ff @(posedge r_to_v_clk or negedge r_to_v_rst_n) begin
    if (!r_to_v_rst_n) begin
      grey_sh <= '0;
    end else begin
      grey_sh <= {grey_sh[SLOT_BITS-2:0], grey_in};
    end
  end

  // One-deep tag/black pipeline; a real slot's result is published one slot later.
  always_ff @(posedge r_to_v_clk or negedge r_to_v_rst_n) begin
    if (!r_to_v_rst_n) begin
      tag_q     <= 1'b0;
      black_q   <= 1'b0;
      res_valid <= 1'b0;
      grey_out  <= '0;
      black_out <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (slot_end) begin
        tag_q   <= sh_real;
        black_q <= black_in;
        if (tag_q) begin
          res_valid <= 1'b1;
          grey_out  <= {grey_sh[SLOT_BITS-2:0], grey_in};
          black_out <= black_q;
        end
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, grey_in, black_in, sh_real};
  assign res_valid = 1'b0;
  assign grey_out  = '0;
  assign black_out = 1'b0;
`endif

endmodule
